// File: rtl/if_fetch_unit_if.sv
// Instruction-fetch bus bundle: memory request/response, decode back-pressure,
// branch redirect and the instruction presented to the IF/ID buffer.
interface if_fetch_unit_if;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [IW-1:0] instruc_out;
    logic [AW-1:0] addr_out;
    logic          valid_out;

    modport master (
        output imem_req, imem_addr, instruc_out, addr_out, valid_out,
        input  imem_ack, imem_rdata, stall, redirect, redirect_addr
    );

    modport slave (
        input  imem_req, imem_addr, instruc_out, addr_out, valid_out,
        output imem_ack, imem_rdata, stall, redirect, redirect_addr
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry
// queue whose head drives decode; redirects flush and may discard an in-flight ack.
module if_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    if_fetch_unit_if.master bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;

    typedef enum logic {ST_FETCH, ST_DISCARD} state_e;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] addr;
    } entry_t;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic          req_q, req_d;
    logic [1:0]    count_q, count_d;
    logic          valid_q, valid_d;
    entry_t        e0_q, e0_d, e1_q, e1_d;

    logic          ack_v;
    logic          push;
    logic          pop;
    entry_t        new_e;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            maddr_q <= RESET_PC;
            req_q   <= 1'b0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            maddr_q <= maddr_d;
            req_q   <= req_d;
            count_q <= count_d;
            valid_q <= valid_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    // Next-state: redirect wins over everything, then queue push/pop
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;

        ack_v = req_q & bus.imem_ack;
        pop   = valid_q & ~bus.stall;
        push  = (state_q == ST_FETCH) & ack_v & ~bus.redirect;
        new_e = {bus.imem_rdata, pc_q};

        if (bus.redirect) begin
            count_d = 2'd0;
            pc_d    = bus.redirect_addr;
            if (state_q == ST_FETCH) begin
                state_d = (req_q & ~bus.imem_ack) ? ST_DISCARD : ST_FETCH;
            end else begin
                state_d = ack_v ? ST_FETCH : ST_DISCARD;
            end
        end else begin
            if ((state_q == ST_DISCARD) && ack_v) begin
                state_d = ST_FETCH;
            end
            if (push) begin
                pc_d = pc_q + 8'd1;
            end
            case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_d = new_e;
                    end else begin
                        e0_d = e1_q;
                        e1_d = new_e;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_d = new_e;
                    end else begin
                        e1_d = new_e;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end

        valid_d = (count_d != 2'd0);
        req_d   = (state_d == ST_DISCARD) | (count_d != 2'd2);
        // While discarding, the old request address must stay on the bus
        maddr_d = (state_d == ST_DISCARD) ? maddr_q : pc_d;
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = maddr_q;
    assign bus.valid_out   = valid_q;
    assign bus.instruc_out = e0_q.instr;
    assign bus.addr_out    = e0_q.addr;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall/full, wrap, redirects
// with wait states and discard, and asynchronous reset.
module tb_if_fetch_unit;
    logic clk;
    logic rst_n;
    logic mem_en;
    logic ack_man;
    int   checks;
    int   errors;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Memory: zero-wait auto-ack when mem_en, else manual ack; data = 1000+addr
    assign bus.imem_ack   = mem_en ? bus.imem_req : ack_man;
    assign bus.imem_rdata = 16'h1000 + {8'h00, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.valid_out, bus.instruc_out, bus.addr_out, bus.imem_req} !== {1'b0, 16'h0000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b i=%h a=%h req=%b, want 0/0000/00/0",
                     bus.valid_out, bus.instruc_out, bus.addr_out, bus.imem_req);
        end
    endtask

    task automatic test_stream();
        mem_en = 1'b1;
        rst_n  = 1'b1;
        tick();
        checks++;
        if ({bus.imem_req, bus.imem_addr, bus.valid_out} !== {1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL stream_first_req: got req=%b addr=%h v=%b, want 1/00/0",
                     bus.imem_req, bus.imem_addr, bus.valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            logic [7:0]  ea;
            logic [15:0] ei;
            ea = 8'(i);
            ei = 16'h1000 + 16'(i);
            tick();
            checks++;
            if ({bus.valid_out, bus.addr_out, bus.instruc_out, bus.imem_addr} !== {1'b1, ea, ei, ea + 8'd1}) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b a=%h i=%h ma=%h, want 1/%h/%h/%h",
                         i, bus.valid_out, bus.addr_out, bus.instruc_out, bus.imem_addr, ea, ei, ea + 8'd1);
            end
        end
    endtask

    task automatic test_stall_full();
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, 8'h03, 16'h1003}) begin
            errors++;
            $display("FAIL stall_head: got v=%b a=%h i=%h, want 1/03/1003",
                     bus.valid_out, bus.addr_out, bus.instruc_out);
        end
        bus.stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({bus.valid_out, bus.addr_out, bus.instruc_out, bus.imem_req} !== {1'b1, 8'h03, 16'h1003, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b a=%h i=%h req=%b, want 1/03/1003/0",
                         k, bus.valid_out, bus.addr_out, bus.instruc_out, bus.imem_req);
            end
        end
        bus.stall = 1'b0;
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out, bus.imem_req, bus.imem_addr} !==
            {1'b1, 8'h04, 16'h1004, 1'b1, 8'h05}) begin
            errors++;
            $display("FAIL stall_release_04: got v=%b a=%h i=%h req=%b ma=%h, want 1/04/1004/1/05",
                     bus.valid_out, bus.addr_out, bus.instruc_out, bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, 8'h05, 16'h1005}) begin
            errors++;
            $display("FAIL stall_release_05: got v=%b a=%h i=%h, want 1/05/1005",
                     bus.valid_out, bus.addr_out, bus.instruc_out);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_a [4];
        logic [15:0] exp_i [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_i = '{16'h10FE, 16'h10FF, 16'h1000, 16'h1001};
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'hFE;
        tick();
        bus.redirect = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'hFE}) begin
            errors++;
            $display("FAIL wrap_redirect: got v=%b req=%b ma=%h, want 0/1/FE",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, exp_a[i], exp_i[i]}) begin
                errors++;
                $display("FAIL wrap_%0d: got v=%b a=%h i=%h, want 1/%h/%h",
                         i, bus.valid_out, bus.addr_out, bus.instruc_out, exp_a[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_redirect_wait();
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h10;
        tick();
        bus.redirect = 1'b0;
        mem_en       = 1'b0;
        ack_man      = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL rw_setup: got v=%b req=%b ma=%h, want 0/1/10",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        tick();
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h40;
        tick();
        bus.redirect = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL rw_discard_hold: got v=%b req=%b ma=%h, want 0/1/10",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        tick();
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h40}) begin
            errors++;
            $display("FAIL rw_after_ack: got v=%b req=%b ma=%h, want 0/1/40",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        mem_en = 1'b1;
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, 8'h40, 16'h1040}) begin
            errors++;
            $display("FAIL rw_first: got v=%b a=%h i=%h, want 1/40/1040",
                     bus.valid_out, bus.addr_out, bus.instruc_out);
        end
    endtask

    task automatic test_redirect_stall_ack();
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h20;
        bus.stall         = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h20}) begin
            errors++;
            $display("FAIL rsa_flush: got v=%b req=%b ma=%h, want 0/1/20",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, 8'h20, 16'h1020}) begin
            errors++;
            $display("FAIL rsa_first: got v=%b a=%h i=%h, want 1/20/1020",
                     bus.valid_out, bus.addr_out, bus.instruc_out);
        end
    endtask

    task automatic test_discard_redirect();
        mem_en            = 1'b0;
        ack_man           = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 8'h50;
        tick();
        bus.redirect_addr = 8'h60;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h21}) begin
            errors++;
            $display("FAIL dr_enter: got v=%b req=%b ma=%h, want 0/1/21",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        tick();
        bus.redirect = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h21}) begin
            errors++;
            $display("FAIL dr_second: got v=%b req=%b ma=%h, want 0/1/21",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        checks++;
        if ({bus.valid_out, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 8'h60}) begin
            errors++;
            $display("FAIL dr_after_ack: got v=%b req=%b ma=%h, want 0/1/60",
                     bus.valid_out, bus.imem_req, bus.imem_addr);
        end
        mem_en = 1'b1;
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, 8'h60, 16'h1060}) begin
            errors++;
            $display("FAIL dr_first: got v=%b a=%h i=%h, want 1/60/1060",
                     bus.valid_out, bus.addr_out, bus.instruc_out);
        end
    endtask

    task automatic test_async_reset();
        bus.stall = 1'b1;
        mem_en    = 1'b0;
        ack_man   = 1'b0;
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.imem_req, bus.imem_addr} !== {1'b1, 8'h60, 1'b1, 8'h61}) begin
            errors++;
            $display("FAIL ar_pre: got v=%b a=%h req=%b ma=%h, want 1/60/1/61",
                     bus.valid_out, bus.addr_out, bus.imem_req, bus.imem_addr);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.valid_out, bus.instruc_out, bus.addr_out, bus.imem_req, bus.imem_addr} !==
            {1'b0, 16'h0000, 8'h00, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL ar_immediate: got v=%b i=%h a=%h req=%b ma=%h, want 0/0000/00/0/00",
                     bus.valid_out, bus.instruc_out, bus.addr_out, bus.imem_req, bus.imem_addr);
        end
        ack_man   = 1'b1;
        bus.stall = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.valid_out, bus.instruc_out, bus.addr_out, bus.imem_req} !== {1'b0, 16'h0000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL ar_ack_ignored: got v=%b i=%h a=%h req=%b, want 0/0000/00/0",
                     bus.valid_out, bus.instruc_out, bus.addr_out, bus.imem_req);
        end
        ack_man = 1'b0;
        mem_en  = 1'b1;
        rst_n   = 1'b1;
        tick();
        checks++;
        if ({bus.imem_req, bus.imem_addr, bus.valid_out} !== {1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL ar_first_req: got req=%b ma=%h v=%b, want 1/00/0",
                     bus.imem_req, bus.imem_addr, bus.valid_out);
        end
        tick();
        checks++;
        if ({bus.valid_out, bus.addr_out, bus.instruc_out} !== {1'b1, 8'h00, 16'h1000}) begin
            errors++;
            $display("FAIL ar_first_data: got v=%b a=%h i=%h, want 1/00/1000",
                     bus.valid_out, bus.addr_out, bus.instruc_out);
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b1;
        mem_en            = 1'b0;
        ack_man           = 1'b0;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 8'h00;
        #2;
        rst_n = 1'b0;

        test_reset();
        test_stream();
        test_stall_full();
        test_wrap();
        test_redirect_wait();
        test_redirect_stall_ack();
        test_discard_redirect();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
